// File: rtl/bk_add_arbiter.sv
// bk_add_arbiter: round-robin arbiter in front of one shared Brent-Kung
// adder, with locked multi-word bursts that chain the carry between beats.

module bk_prefix_add #(
  parameter int W = 16
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic         cin,
  output logic [W:0]   sum
);

  localparam int L = $clog2(W);

  logic [W-1:0] p;
  logic [W-1:0] g;
  logic [W-1:0] pg;

  // g[i] ends up as the carry out of bit i, with cin folded into bit 0
  always_comb begin
    p     = x ^ y;
    g     = x & y;
    g[0]  = g[0] | (p[0] & cin);
    pg    = p;
    for (int d = 0; d < L; d++) begin
      for (int i = 0; i < W; i++) begin
        if ((i + 1) % (2 << d) == 0) begin
          g[i]  = g[i] | (pg[i] & g[i - (1 << d)]);
          pg[i] = pg[i] & pg[i - (1 << d)];
        end
      end
    end
    for (int d = L - 2; d >= 0; d--) begin
      for (int i = 0; i < W; i++) begin
        if ((i + 1 >= (3 << d)) &&
            ((i + 1 - (3 << d)) % (2 << d) == 0)) begin
          g[i] = g[i] | (pg[i] & g[i - (1 << d)]);
        end
      end
    end
    sum = {g[W-1], p ^ {g[W-2:0], cin}};
  end

endmodule

module bk_add_arbiter #(
  parameter int NREQ = 4,
  parameter int W    = 16,
  parameter int IDW  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*W-1:0] req_x,
  input  logic [NREQ*W-1:0] req_y,
  input  logic [NREQ-1:0]   req_last,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [W:0]        rsp_sum,
  output logic [IDW-1:0]    rsp_id,
  output logic              rsp_last,
  output logic              busy
);

  typedef enum logic {
    IDLE,
    LOCK
  } state_t;

  state_t         state;
  state_t         state_nx;
  logic [IDW-1:0] rr_ptr;
  logic [IDW-1:0] lock_id;
  logic [IDW-1:0] gnt;
  logic [IDW-1:0] sel;
  logic [IDW-1:0] nxt_ptr;
  logic           found;
  logic           can_acc;
  logic           xfer;
  logic           carry_q;
  logic           cin;
  logic [W-1:0]   opx;
  logic [W-1:0]   opy;
  logic [W:0]     sum;

  always_comb begin
    logic [IDW-1:0] idx;
    idx   = '0;
    gnt   = '0;
    found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      idx = IDW'((int'(rr_ptr) + k) % NREQ);
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        gnt   = idx;
      end
    end
  end

  assign can_acc = !rsp_valid || rsp_ready;
  assign sel     = (state == LOCK) ? lock_id : gnt;
  assign busy    = (state == LOCK);

  // the locked requester sees ready even while it has no beat to give
  always_comb begin
    req_ready = '0;
    unique case (state)
      LOCK: req_ready[lock_id] = can_acc;
      IDLE: begin
        if (found) req_ready[gnt] = can_acc;
      end
      default: req_ready = '0;
    endcase
  end

  assign xfer    = req_valid[sel] & req_ready[sel];
  assign nxt_ptr = (sel == IDW'(NREQ - 1)) ? '0 : sel + IDW'(1);

  assign opx = req_x[sel*W +: W];
  assign opy = req_y[sel*W +: W];
  assign cin = (state == LOCK) & carry_q;

  bk_prefix_add #(
    .W (W)
  ) u_add (
    .x   (opx),
    .y   (opy),
    .cin (cin),
    .sum (sum)
  );

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (xfer && !req_last[sel]) state_nx = LOCK;
      end
      LOCK: begin
        if (xfer && req_last[sel]) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr    <= '0;
      lock_id   <= '0;
      carry_q   <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_sum   <= '0;
      rsp_id    <= '0;
      rsp_last  <= 1'b0;
    end else begin
      if (xfer) begin
        carry_q  <= sum[W];
        rsp_sum  <= sum;
        rsp_id   <= sel;
        rsp_last <= req_last[sel];
        if (req_last[sel]) rr_ptr  <= nxt_ptr;
        else               lock_id <= sel;
      end
      if (xfer)           rsp_valid <= 1'b1;
      else if (rsp_ready) rsp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_bk_add_arbiter.sv
// tb_bk_add_arbiter: vector table, directed corner sequences and a
// randomized burst run scored against a multi-word arithmetic model.

module tb_bk_add_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [63:0] req_x;
  logic [63:0] req_y;
  logic [3:0]  req_last;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [16:0] rsp_sum;
  logic [1:0]  rsp_id;
  logic        rsp_last;
  logic        busy;

  int nerr = 0;
  int nchk = 0;

  always #5 clk = ~clk;

  bk_add_arbiter #(
    .NREQ (4),
    .W    (16),
    .IDW  (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_x     (req_x),
    .req_y     (req_y),
    .req_last  (req_last),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_sum   (rsp_sum),
    .rsp_id    (rsp_id),
    .rsp_last  (rsp_last),
    .busy      (busy)
  );

  typedef struct {
    int          id;
    logic [15:0] x;
    logic [15:0] y;
    logic [16:0] s;
  } vec_t;

  vec_t tbl[7];

  logic [15:0] ax[4][8];
  logic [15:0] ay[4][8];
  logic [16:0] ae[4][8];
  int          alen[4];
  int          aidx[4];
  bit          av[4];
  logic [19:0] q[$];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic setreq(input int i, input logic v, input logic [15:0] x,
                        input logic [15:0] y, input logic l);
    req_valid[i +: 1]  = v;
    req_last[i +: 1]   = l;
    req_x[i*16 +: 16]  = x;
    req_y[i*16 +: 16]  = y;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    req_valid = '0;
    req_last  = '0;
    req_x     = '0;
    req_y     = '0;
    rsp_ready = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  function automatic logic [15:0] rword();
    case ($urandom_range(0, 4))
      0:       return 16'hFFFF;
      1:       return 16'h0000;
      default: return 16'($urandom);
    endcase
  endfunction

  // expected beat k = low k+1 words of X+Y, carry taken at that boundary
  task automatic new_burst(input int i);
    logic [143:0] bx;
    logic [143:0] by;
    logic [143:0] m;
    logic [143:0] t;
    bx = '0;
    by = '0;
    alen[i] = $urandom_range(1, 8);
    for (int k = 0; k < alen[i]; k++) begin
      ax[i][k] = rword();
      ay[i][k] = rword();
      bx[16*k +: 16] = ax[i][k];
      by[16*k +: 16] = ay[i][k];
    end
    for (int k = 0; k < alen[i]; k++) begin
      m = (144'd1 << (16 * (k + 1))) - 144'd1;
      t = (bx & m) + (by & m);
      ae[i][k] = {t[16*(k+1)], t[16*k +: 16]};
    end
    aidx[i] = 0;
  endtask

  task automatic drive_agents();
    for (int i = 0; i < 4; i++) begin
      setreq(i, av[i], ax[i][aidx[i]], ay[i][aidx[i]],
             aidx[i] == alen[i] - 1);
    end
  endtask

  task automatic run_random();
    int   mptr;
    int   mlock;
    bit   mfull;
    bit   cacc;
    int   g;
    int   j;
    int   beats;
    int   cyc;
    bit   xf;
    bit   lst;
    logic [3:0]  erdy;
    logic [19:0] e;
    do_reset();
    mptr  = 0;
    mlock = -1;
    mfull = 1'b0;
    beats = 0;
    cyc   = 0;
    q.delete();
    for (int i = 0; i < 4; i++) begin
      new_burst(i);
      av[i] = 1'b0;
    end
    while (beats < 10000 && cyc < 60000) begin
      cyc++;
      drive_agents();
      rsp_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      cacc = !mfull || rsp_ready;
      g    = -1;
      if (mlock >= 0) begin
        g = mlock;
      end else begin
        for (int k = 0; k < 4; k++) begin
          j = (mptr + k) % 4;
          if (g < 0 && av[j]) g = j;
        end
      end
      erdy = (g >= 0 && cacc) ? (4'd1 << g) : 4'd0;
      chk("rnd_ready", 32'(req_ready), 32'(erdy));
      chk("rnd_valid", 32'(rsp_valid), 32'(mfull));
      chk("rnd_busy", 32'(busy), 32'(mlock >= 0));
      if (mfull && rsp_ready) begin
        e = (q.size() > 0) ? q.pop_front() : 20'hFFFFF;
        chk("rnd_rsp", 32'({rsp_last, rsp_id, rsp_sum}), 32'(e));
      end
      xf    = (g >= 0) && cacc && av[g];
      mfull = xf || (mfull && !rsp_ready);
      if (xf) begin
        lst = (aidx[g] == alen[g] - 1);
        q.push_back({lst, 2'(g), ae[g][aidx[g]]});
        beats++;
        if (lst) begin
          mptr  = (g + 1) % 4;
          mlock = -1;
          av[g] = 1'b0;
          new_burst(g);
        end else begin
          mlock = g;
          aidx[g]++;
          av[g] = ($urandom_range(0, 3) != 0);
        end
      end
      for (int i = 0; i < 4; i++) begin
        if (!av[i]) av[i] = ($urandom_range(0, 2) == 0);
      end
      tick();
    end
    chk("rnd_beats_done", 32'(beats >= 10000), 32'd1);
  endtask

  initial begin
    tbl[0] = '{0, 16'h0001, 16'h0002, 17'h00003};
    tbl[1] = '{1, 16'hFFFF, 16'hFFFF, 17'h1FFFE};
    tbl[2] = '{2, 16'h0000, 16'h0000, 17'h00000};
    tbl[3] = '{3, 16'hFFFF, 16'h0001, 17'h10000};
    tbl[4] = '{0, 16'h8000, 16'h8000, 17'h10000};
    tbl[5] = '{2, 16'h1234, 16'h4321, 17'h05555};
    tbl[6] = '{1, 16'h7FFF, 16'h0001, 17'h08000};

    do_reset();
    @(negedge clk);
    chk("rst_valid", 32'(rsp_valid), 32'd0);
    chk("rst_sum", 32'(rsp_sum), 32'd0);
    chk("rst_id", 32'(rsp_id), 32'd0);
    chk("rst_last", 32'(rsp_last), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    tick();

    foreach (tbl[n]) begin
      setreq(tbl[n].id, 1'b1, tbl[n].x, tbl[n].y, 1'b1);
      rsp_ready = 1'b1;
      @(negedge clk);
      chk("tbl_ready", 32'(req_ready), 32'd1 << tbl[n].id);
      tick();
      setreq(tbl[n].id, 1'b0, 16'h0, 16'h0, 1'b0);
      @(negedge clk);
      chk("tbl_valid", 32'(rsp_valid), 32'd1);
      chk("tbl_sum", 32'(rsp_sum), 32'(tbl[n].s));
      chk("tbl_id", 32'(rsp_id), 32'(tbl[n].id));
      chk("tbl_last", 32'(rsp_last), 32'd1);
      tick();
    end

    // all requesters valid: grants rotate 0,1,2,3,0
    do_reset();
    rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      setreq(i, 1'b1, 16'(i + 1), 16'(16 * i), 1'b1);
    end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("rot_ready", 32'(req_ready), 32'd1 << (k % 4));
      if (k > 0) begin
        chk("rot_id", 32'(rsp_id), 32'((k - 1) % 4));
        chk("rot_sum", 32'(rsp_sum),
            32'(((k - 1) % 4) + 1 + 16 * ((k - 1) % 4)));
      end
      tick();
    end
    req_valid = '0;

    // carry-chained burst from req2 with req1 waiting, plus a valid gap
    do_reset();
    rsp_ready = 1'b1;
    setreq(1, 1'b1, 16'h0005, 16'h0005, 1'b1);
    @(negedge clk);
    chk("bst_pre_ready", 32'(req_ready), 32'b0010);
    tick();
    setreq(2, 1'b1, 16'hFFFF, 16'h0001, 1'b0);
    @(negedge clk);
    chk("bst_b0_ready", 32'(req_ready), 32'b0100);
    chk("bst_pre_sum", 32'(rsp_sum), 32'h0000A);
    tick();
    setreq(2, 1'b0, 16'h0000, 16'h0000, 1'b1);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("bst_gap_busy", 32'(busy), 32'd1);
      chk("bst_gap_ready", 32'(req_ready), 32'b0100);
      if (k == 0) chk("bst_b0_sum", 32'(rsp_sum), 32'h10000);
      tick();
    end
    setreq(2, 1'b1, 16'h0000, 16'h0000, 1'b1);
    @(negedge clk);
    chk("bst_b1_ready", 32'(req_ready), 32'b0100);
    tick();
    setreq(2, 1'b0, 16'h0000, 16'h0000, 1'b0);
    @(negedge clk);
    chk("bst_b1_sum", 32'(rsp_sum), 32'h00001);
    chk("bst_b1_id", 32'(rsp_id), 32'd2);
    chk("bst_b1_last", 32'(rsp_last), 32'd1);
    chk("bst_idle", 32'(busy), 32'd0);
    chk("bst_next_ready", 32'(req_ready), 32'b0010);
    tick();
    setreq(1, 1'b0, 16'h0000, 16'h0000, 1'b0);
    @(negedge clk);
    chk("bst_req1_id", 32'(rsp_id), 32'd1);
    tick();

    // backpressure: output held, nothing accepted, then pop and push
    do_reset();
    setreq(0, 1'b1, 16'h0010, 16'h0020, 1'b1);
    @(negedge clk);
    chk("bp_push_ready", 32'(req_ready), 32'b0001);
    tick();
    setreq(0, 1'b0, 16'h0000, 16'h0000, 1'b0);
    setreq(3, 1'b1, 16'h0007, 16'h0008, 1'b1);
    repeat (5) begin
      @(negedge clk);
      chk("bp_ready", 32'(req_ready), 32'd0);
      chk("bp_hold", 32'({rsp_valid, rsp_id, rsp_sum}),
          32'({1'b1, 2'd0, 17'h00030}));
      tick();
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_release", 32'(req_ready), 32'b1000);
    tick();
    setreq(3, 1'b0, 16'h0000, 16'h0000, 1'b0);
    @(negedge clk);
    chk("bp_next", 32'({rsp_valid, rsp_id, rsp_sum}),
        32'({1'b1, 2'd3, 17'h0000F}));
    tick();

    // reset in LOCK drops the burst, pointer and carry
    do_reset();
    rsp_ready = 1'b1;
    setreq(2, 1'b1, 16'h0001, 16'h0001, 1'b1);
    tick();
    setreq(2, 1'b0, 16'h0000, 16'h0000, 1'b0);
    setreq(0, 1'b1, 16'hFFFF, 16'h0001, 1'b0);
    @(negedge clk);
    chk("rl_b0_ready", 32'(req_ready), 32'b0001);
    tick();
    rst = 1'b1;
    setreq(0, 1'b1, 16'h0000, 16'h0000, 1'b1);
    tick();
    rst = 1'b0;
    setreq(0, 1'b1, 16'hFFFF, 16'h0001, 1'b1);
    setreq(3, 1'b1, 16'h0000, 16'h0000, 1'b1);
    @(negedge clk);
    chk("rl_valid", 32'(rsp_valid), 32'd0);
    chk("rl_busy", 32'(busy), 32'd0);
    chk("rl_ptr", 32'(req_ready), 32'b0001);
    tick();
    req_valid = '0;
    @(negedge clk);
    chk("rl_cin", 32'(rsp_sum), 32'h10000);
    chk("rl_id", 32'(rsp_id), 32'd0);
    tick();

    run_random();

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/bk_add_arbiter.md
Name: bk_add_arbiter

Overview:
- Shares one 16-bit Brent-Kung prefix adder (X + Y + Cin, 17-bit result) between NREQ requesters.
- Round-robin arbitration with valid/ready handshakes on every port.
- Multi-word (chained) additions: a requester may issue a burst of beats; the arbiter locks to it and feeds each beat's carry-out into the next beat's Cin.
- Sits between the address/ALU request clients and the shared adder instance; result is registered in a 1-entry output buffer.

Parameters:
- NREQ, 4, number of requesters (2..8).
- W, 16, operand width; fixed to the adder width.
- IDW, 2, width of rsp_id; must equal clog2(NREQ).

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  NREQ  per-requester beat valid.
- req_ready  output  NREQ  per-requester beat accepted (one-hot or zero).
- req_x  input  NREQ*W  operand X, requester i at [i*W +: W].
- req_y  input  NREQ*W  operand Y, same packing.
- req_last  input  NREQ  1 = final (or only) beat of a burst.
- rsp_valid  output  1  result available.
- rsp_ready  input  1  consumer accepts result.
- rsp_sum  output  W+1  {carry_out, sum}.
- rsp_id  output  IDW  index of the requester that produced the result.
- rsp_last  output  1  copy of req_last of the beat.
- busy  output  1  high while the arbiter is in LOCK.

Behaviour:
- Reset values (one clk edge with rst=1): rsp_valid=0, rsp_sum=0, rsp_id=0, rsp_last=0, busy=0, rr_ptr=0, carry_q=0, state=IDLE.
  - Reset mid-burst abandons the burst; no response is emitted for it.
- Accept condition (can_acc): rsp_valid=0, or (rsp_valid=1 and rsp_ready=1). The same-cycle pop-and-push gives full throughput of 1 beat/cycle.
- IDLE state:
  - grant = first i with req_valid[i]=1, searching from rr_ptr upward with wrap-around mod NREQ.
  - req_ready[grant]=1 only if can_acc; all other req_ready bits are 0.
  - On transfer: Cin=0; the adder computes req_x+req_y+0; the output register loads {cout,sum}, id=grant, last=req_last[grant]; rsp_valid goes 1 next cycle (latency 1).
  - On transfer, carry_q takes cout.
  - If req_last[grant]=1: rr_ptr takes (grant+1) mod NREQ; stay in IDLE.
  - If req_last[grant]=0: lock_id takes grant; go to LOCK; busy=1.
- LOCK state:
  - Only requester lock_id is eligible; req_ready[lock_id]=can_acc; all others are 0 regardless of their valid.
  - On transfer: Cin=carry_q; carry_q takes the new cout.
  - If req_last=1: rr_ptr takes (lock_id+1) mod NREQ; go to IDLE; busy=0.
  - If the locked requester drops req_valid, wait in LOCK indefinitely; there is no timeout.
- No beat is ever transferred while can_acc=0. Operands must be held stable by the requester until req_ready (standard valid/ready).
- Output holds its value while rsp_valid=1 and rsp_ready=0.
- Arithmetic:
  - rsp_sum = req_x + req_y + Cin, computed in W+1 bits.
  - Combining chained beats LSW-first gives the exact multi-word sum. The final beat's bit W is the overall carry.
- Fairness: after a completed burst the granted requester becomes lowest priority. With all requesters continuously valid with single-beat requests, grants rotate 0,1,2,3,0,...
- Datapath: a single adder instance; the operand mux is driven by the grant, and Cin by state.
- Combinational path req_valid -> req_ready is allowed; there is no combinational path from req_* to rsp_*.

Test Plan:
- Reset, then req0 valid x=0x0001 y=0x0002 last=1, rsp_ready=1 -> req_ready=0001b same cycle; next cycle rsp_valid=1, rsp_sum=0x00003, rsp_id=0.
- All 4 requesters valid, single beats, rsp_ready=1 -> grants 0,1,2,3,0 on consecutive cycles; one response per cycle with matching ids.
- req2 two-beat burst: beat0 FFFF+0001 last=0, beat1 0000+0000 last=1; req1 valid throughout -> responses 0x10000 then 0x00001 (carry propagated), both id=2; req1 is granted only after beat1; busy=1 between beats.
- Backpressure: rsp_ready=0 with a result held -> all req_ready=0, rsp_* stable for 5 cycles; raise rsp_ready -> the pending result pops and the next beat is accepted in the same cycle.
- rst asserted in LOCK after beat0 of a burst -> next cycle rsp_valid=0, busy=0, rr_ptr=0; a fresh beat gets Cin=0 (FFFF+0001 -> 0x10000, not 0x10001).
- Corner sums: 0xFFFF+0xFFFF -> 0x1FFFE; 0x0000+0x0000 -> 0x00000; random 10k beats against a reference model, including bursts up to 8 beats.
